// File: rtl/accum_seq.sv
// rtl/accum_seq.sv - issue-side sequencer tagging DPE results with accumulator address/accum/last
// Stalls upstream so an address is never reissued within MIN_GAP cycles of its previous issue.
module accum_seq #(
  parameter int DATAW   = 32,
  parameter int DEPTH   = 512,
  parameter int ADDRW   = $clog2(DEPTH),
  parameter int NUMW    = 16,
  parameter int MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ADDRW:0]   cfg_num_rows,
  input  logic [NUMW-1:0]  cfg_num_subsets,
  input  logic             i_valid,
  input  logic [DATAW-1:0] i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [DATAW-1:0] o_data,
  output logic [ADDRW-1:0] o_addr,
  output logic             o_accum,
  output logic             o_last,
  output logic             o_done,
  output logic             busy
);

  localparam int HIST = MIN_GAP - 1;
  localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [ADDRW-1:0] row, last_row;
  logic [NUMW-1:0]  subset, last_subset;
  logic [HIST-1:0]  hist_valid;
  logic [ADDRW-1:0] hist_addr [HIST];
  logic             hazard, accept, cfg_accept, row_wrap, final_beat;

  assign accept     = i_valid && i_ready;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign row_wrap   = (row == last_row);
  assign final_beat = row_wrap && (subset == last_subset);

  // hist[0] is the beat currently on the output; an accept now lands one cycle later
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < HIST; k++) begin
      if (hist_valid[k] && (hist_addr[k] == row)) hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_accept) state_next = RUN;
      RUN:     if (accept && final_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state != IDLE);
    i_ready   = (state == RUN) && !hazard;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_addr      <= '0;
      o_accum     <= 1'b0;
      o_last      <= 1'b0;
      o_done      <= 1'b0;
      row         <= '0;
      subset      <= '0;
      last_row    <= '0;
      last_subset <= '0;
      hist_valid  <= '0;
      for (int k = 0; k < HIST; k++) hist_addr[k] <= '0;
    end else begin
      o_valid <= accept;
      o_done  <= accept && final_beat;
      if (accept) begin
        o_data  <= i_data;
        o_addr  <= row;
        o_accum <= (subset != '0);
        o_last  <= (subset == last_subset);
      end

      hist_valid[0] <= accept;
      hist_addr[0]  <= row;
      for (int k = 1; k < HIST; k++) begin
        hist_valid[k] <= hist_valid[k-1];
        hist_addr[k]  <= hist_addr[k-1];
      end

      if (cfg_accept) begin
        row         <= '0;
        subset      <= '0;
        last_row    <= (cfg_num_rows == '0)    ? '0 :
                       (cfg_num_rows > DEPTH_W) ? ADDRW'(DEPTH - 1) :
                       ADDRW'(cfg_num_rows - (ADDRW+1)'(1));
        last_subset <= (cfg_num_subsets == '0) ? '0 : cfg_num_subsets - NUMW'(1);
      end else if (accept) begin
        if (row_wrap) begin
          row    <= '0;
          subset <= subset + NUMW'(1);
        end else begin
          row <= row + ADDRW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// tb/tb_accum_seq.sv - self-checking bench for accum_seq against a beat-index reference model
module tb_accum_seq;

  localparam int DATAW   = 32;
  localparam int DEPTH   = 512;
  localparam int ADDRW   = 9;
  localparam int NUMW    = 16;
  localparam int MIN_GAP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [ADDRW:0]   cfg_num_rows = '0;
  logic [NUMW-1:0]  cfg_num_subsets = '0;
  logic             i_valid = 1'b0;
  logic [DATAW-1:0] i_data = '0;
  logic             i_ready;
  logic             o_valid;
  logic [DATAW-1:0] o_data;
  logic [ADDRW-1:0] o_addr;
  logic             o_accum, o_last, o_done, busy;

  accum_seq #(.DATAW(DATAW), .DEPTH(DEPTH), .NUMW(NUMW), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_rows(cfg_num_rows), .cfg_num_subsets(cfg_num_subsets),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr),
    .o_accum(o_accum), .o_last(o_last), .o_done(o_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: phase 0 idle / 1 run / 2 done; beat k -> row k%rows, subset k/rows
  int phase = 0;
  int m_rows = 1, m_subs = 1, m_k = 0, m_p = 0;
  int last_out [DEPTH];
  logic             exp_valid = 0, exp_done = 0, exp_accum = 0, exp_last = 0;
  logic [DATAW-1:0] exp_data = '0;
  logic [ADDRW-1:0] exp_addr = '0;

  int dut_beats, dut_dones, dut_first_t, dut_done_t, dut_max_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    phase = 0; m_k = 0; m_rows = 1; m_subs = 1;
    for (int a = 0; a < DEPTH; a++) last_out[a] = -100;
    exp_valid = 0; exp_done = 0; exp_accum = 0; exp_last = 0;
    exp_data = '0; exp_addr = '0;
  endtask

  // one clock: check combinational outputs mid-cycle, then registered outputs after the edge
  task automatic step();
    bit exp_ir, acc, cfg_acc;
    int r, s;
    #3;
    r = m_k % m_rows;
    exp_ir  = (phase == 1) && ((m_p + 1 - last_out[r]) >= MIN_GAP);
    chk("cfg_ready", cfg_ready, phase == 0);
    chk("busy", busy, phase != 0);
    chk("i_ready", i_ready, exp_ir);
    acc     = rst && i_valid && exp_ir;
    cfg_acc = rst && cfg_valid && (phase == 0);
    @(posedge clk);
    #1;
    m_p++;
    if (!rst) begin
      model_clear();
    end else begin
      exp_valid = acc;
      exp_done  = 0;
      if (phase == 2) phase = 0;
      if (acc) begin
        r = m_k % m_rows;
        s = m_k / m_rows;
        exp_data  = i_data;
        exp_addr  = ADDRW'(r);
        exp_accum = (s != 0);
        exp_last  = (s == m_subs - 1);
        last_out[r] = m_p;
        m_k++;
        if (m_k == m_rows * m_subs) begin
          exp_done = 1;
          phase = 2;
        end
      end else if (cfg_acc) begin
        phase  = 1;
        m_k    = 0;
        m_rows = (cfg_num_rows == 0) ? 1 : (cfg_num_rows > DEPTH) ? DEPTH : int'(cfg_num_rows);
        m_subs = (cfg_num_subsets == 0) ? 1 : int'(cfg_num_subsets);
      end
    end
    chk("o_valid", o_valid, exp_valid);
    chk("o_data", o_data, exp_data);
    chk("o_addr", o_addr, exp_addr);
    chk("o_accum", o_accum, exp_accum);
    chk("o_last", o_last, exp_last);
    chk("o_done", o_done, exp_done);
    if (o_valid === 1'b1) begin
      dut_beats++;
      if (dut_beats == 1) dut_first_t = m_p;
      if (int'(o_addr) > dut_max_addr) dut_max_addr = int'(o_addr);
    end
    if (o_done === 1'b1) begin
      dut_dones++;
      dut_done_t = m_p;
    end
  endtask

  // rand_valid: ~50% i_valid; pulse_cfg: re-offer a descriptor mid-job; stop_after: abandon after N beats
  task automatic run_job(input int rows, input int subs, input bit rand_valid,
                         input bit pulse_cfg, input int stop_after);
    int c;
    dut_beats = 0; dut_dones = 0; dut_first_t = 0; dut_done_t = 0; dut_max_addr = 0;
    cfg_valid = 1; cfg_num_rows = (ADDRW+1)'(rows); cfg_num_subsets = NUMW'(subs);
    i_valid = 0;
    step();
    cfg_valid = 0;
    c = 0;
    while (phase != 0 && c < 4000) begin
      i_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      i_data  = $urandom;
      if (pulse_cfg && c == 5) begin
        cfg_valid = 1; cfg_num_rows = 3; cfg_num_subsets = 1;
      end
      step();
      cfg_valid = 0;
      c++;
      if (stop_after != 0 && dut_beats == stop_after) break;
    end
    i_valid = 0;
    if (c >= 4000) chk("job_timeout", 1, 0);
  endtask

  initial begin
    model_clear();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1;
    step();

    run_job(4, 3, 0, 0, 0);
    chk("A_beats", dut_beats, 12);
    chk("A_span", dut_done_t - dut_first_t, 11);
    chk("A_dones", dut_dones, 1);

    run_job(1, 5, 0, 0, 0);
    chk("B_beats", dut_beats, 5);
    chk("B_span", dut_done_t - dut_first_t, 16);

    run_job(2, 3, 0, 0, 0);
    chk("C_beats", dut_beats, 6);
    chk("C_span", dut_done_t - dut_first_t, 9);

    run_job(8, 4, 1, 1, 0);
    chk("D_beats", dut_beats, 32);
    chk("D_dones", dut_dones, 1);

    run_job(0, 0, 0, 0, 0);
    chk("E_beats", dut_beats, 1);

    run_job(600, 2, 0, 0, 0);
    chk("F_beats", dut_beats, 1024);
    chk("F_max_addr", dut_max_addr, 511);

    run_job(4, 3, 0, 0, 5);
    chk("G_partial_beats", dut_beats, 5);
    chk("G_no_done", dut_dones, 0);
    rst = 0;
    i_valid = 1;
    step();
    rst = 1;
    i_valid = 0;
    step();
    run_job(4, 3, 0, 0, 0);
    chk("G_restart_beats", dut_beats, 12);
    chk("G_restart_span", dut_done_t - dut_first_t, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
